count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Downstream consumer of the 4-bit ripple counter output.
- Raw count bits settle at different times, so a direct sample can capture a transient value. This block samples the count into the clk domain and accepts a value only after it holds stable.
- From each accepted value it flags threshold matches and wrap-arounds, and runs a small arm/hit FSM used by the surrounding test logic.

Parameters:
- WIDTH, 4: width of count_in and of all count-sized outputs.
- STABLE_CYCLES, 2: consecutive equal samples required before a value is accepted. Legal range 1..15.
- WRAPW, 8: width of the saturating wrap counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  WIDTH  raw ripple-counter value; may be mid-transition.
- en_in  input  1  counter enable, mirrored from the counter's en.
- threshold  input  WIDTH  match value; sampled at every accept.
- clr_event  input  1  synchronous clear of hit state, wrap_cnt and irq.
- count_stable  output  WIDTH  last accepted value.
- update  output  1  one-cycle pulse when count_stable changes.
- match  output  1  one-cycle pulse when the accepted value equals threshold.
- wrap  output  1  one-cycle pulse when the accepted value is less than the previous count_stable.
- wrap_cnt  output  WRAPW  number of wraps; saturates at all-ones.
- hit  output  1  high while the FSM is in HIT.
- irq  output  1  sticky interrupt; see Optional Feature.

Behaviour:
- Reset, asynchronous and active-high. All of the following clear to 0: s1, s2, stab_cnt, count_stable, update, match, wrap, wrap_cnt, hit, irq. FSM goes to IDLE.
- Sampling. Every cycle: s1 <= count_in, then s2 <= s1.
  - If s1 == s2, stab_cnt increments and saturates at STABLE_CYCLES. Otherwise stab_cnt resets to 0.
- Accept. Occurs when stab_cnt == STABLE_CYCLES and s2 != count_stable. In the next cycle:
  - count_stable <= s2 and update = 1.
  - match = (s2 == threshold).
  - wrap = (s2 < old count_stable). On wrap, wrap_cnt increments, saturating at all-ones.
  - Latency: a count_in value held steady is accepted and visible on count_stable 2+STABLE_CYCLES cycles after it first appears.
- Equal value. A stable value equal to count_stable produces no pulses.
- Multi-step jumps. A jump of more than 1 is accepted normally. Wrap is decided only by the comparison of new and old values.
- FSM, states IDLE, ARMED, HIT; evaluated in this priority order:
  - IDLE: goes to ARMED when en_in = 1.
  - ARMED:
    - If a match accept occurs this cycle, go to HIT. This takes priority over en_in = 0.
    - Otherwise, if en_in = 0, go to IDLE.
  - HIT:
    - If clr_event = 1, go to ARMED when en_in = 1, or to IDLE when en_in = 0.
    - en_in alone does not leave HIT.
  - hit = 1 while the FSM is in HIT (registered state decode).
- clr_event:
  - Clears wrap_cnt and irq in the next cycle.
  - Does not affect count_stable or the sampler.
  - If clr_event and a wrap accept occur in the same cycle, wrap_cnt becomes 1, not 0. Same-cycle events are counted, not lost.
- Accepts continue regardless of en_in and FSM state.
- Reset mid-operation: all state is lost, and the first value accepted after reset is compared against count_stable = 0.

Optional Feature:
- Macro: COUNT_MONITOR_IRQ_EN.
- Defined:
  - irq is set in the cycle after any match or wrap pulse.
  - irq holds until clr_event. Set has priority over clear in the same cycle.
- Undefined: irq is a constant 0 and no irq register is built. All other behaviour is identical.

Decomposition:
- Package count_monitor_pkg holds:
  - the FSM state typedef: IDLE = 2'd0, ARMED = 2'd1, HIT = 2'd2;
  - default constants for WIDTH, STABLE_CYCLES and WRAPW.
- Sub-module stable_sampler, parameterised by WIDTH and STABLE_CYCLES. It contains s1, s2, stab_cnt and accept generation, and outputs accept_valid and accept_value.
- count_monitor holds the compare logic, wrap counter, FSM and irq.

Test Plan:
- Basic accept, defaults, threshold = 9. Reset high for 2 cycles, then count_in = 3 held.
  - Expected: update pulses once, count_stable = 3 four cycles after count_in changes. No match, no wrap.
- Glitch rejection. count_in goes 7 -> 6 for 1 cycle -> 8 held.
  - Expected: 6 is never accepted; count_stable goes 7 -> 8 with a single update pulse.
- Match and FSM. en_in = 1 (FSM reaches ARMED), then step count_in 8 -> 9.
  - Expected: match pulses with the 9 accept, hit = 1 from the next cycle.
  - Then drop en_in: FSM stays in HIT.
  - Then clr_event = 1 with en_in = 0: hit = 0 and FSM in IDLE.
- Wrap. Step count_in through 14, 15, 0, 1.
  - Expected: a single wrap pulse on the 0 accept; wrap_cnt = 1.
  - Repeat the full 0..15 cycle 300 times: wrap_cnt saturates at 255.
- Simultaneous events. clr_event asserted in the same cycle as a wrap accept.
  - Expected: wrap_cnt = 1.
  - With COUNT_MONITOR_IRQ_EN defined: irq = 1 after the cycle.
  - With COUNT_MONITOR_IRQ_EN undefined: irq stays 0 throughout.
- Reset mid-run. With count_stable = 12, assert rst asynchronously, between clock edges.
  - Expected: all outputs are 0 immediately.
  - After release with count_in = 12 held: 12 is re-accepted with update = 1 and wrap = 0.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and default constants for count_monitor.
//   DEF_WIDTH          default width of the monitored count
//   DEF_STABLE_CYCLES  default number of equal samples needed before accept
//   DEF_WRAPW          default width of the saturating wrap counter
//   state_e            arm/hit FSM state encoding
package count_monitor_pkg;

   localparam int unsigned DEF_WIDTH         = 4;
   localparam int unsigned DEF_STABLE_CYCLES = 2;
   localparam int unsigned DEF_WRAPW         = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } state_e;

endpackage

// File: rtl/count_monitor_stable_sampler.sv
// stable_sampler: double-samples a possibly mid-transition count into the clk
// domain and flags a value as acceptable once it has held for STABLE_CYCLES.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   sample_in     raw count value
//   current       currently accepted value (owned by the parent)
//   accept_valid  combinational: accept s2 at the coming edge
//   accept_value  value to accept (s2)
module stable_sampler
   import count_monitor_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_in,
   input  logic [WIDTH-1:0] current,
   output logic             accept_valid,
   output logic [WIDTH-1:0] accept_value
);

   localparam int unsigned CNTW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNTW-1:0] STAB_MAX = CNTW'(STABLE_CYCLES);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [CNTW-1:0]  stab_cnt_q, stab_cnt_d;

   always_comb begin
      stab_cnt_d = '0;
      if (s1_q == s2_q) begin
         stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + CNTW'(1);
      end
   end

   // Accept on the edge where the stability count reaches its target, so a
   // steady input shows up on count_stable 2+STABLE_CYCLES edges after it appears.
   assign accept_valid = (stab_cnt_d == STAB_MAX) && (s2_q != current);
   assign accept_value = s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         stab_cnt_q <= '0;
      end else begin
         s1_q       <= sample_in;
         s2_q       <= s1_q;
         stab_cnt_q <= stab_cnt_d;
      end
   end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: accepts stable values of a ripple-counter output, flags
// threshold matches and wrap-arounds, counts wraps and runs an arm/hit FSM.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   count_in      raw counter value; en_in counter enable
//   threshold     match value; clr_event clears hit state, wrap_cnt and irq
//   count_stable  last accepted value; update/match/wrap one-cycle pulses
//   wrap_cnt      saturating wrap count; hit FSM-in-HIT; irq sticky interrupt
// Build option: define COUNT_MONITOR_IRQ_EN to build the irq register,
// otherwise irq is tied to 0.
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned WRAPW         = DEF_WRAPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count_in,
   input  logic             en_in,
   input  logic [WIDTH-1:0] threshold,
   input  logic             clr_event,
   output logic [WIDTH-1:0] count_stable,
   output logic             update,
   output logic             match,
   output logic             wrap,
   output logic [WRAPW-1:0] wrap_cnt,
   output logic             hit,
   output logic             irq
);

   logic             accept_valid;
   logic [WIDTH-1:0] accept_value;
   logic             is_match, is_wrap;

   logic [WIDTH-1:0] count_stable_q, count_stable_d;
   logic             update_q, update_d;
   logic             match_q, match_d;
   logic             wrap_q, wrap_d;
   logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
   state_e           state_q, state_d;

   stable_sampler #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_sampler (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (count_in),
      .current      (count_stable_q),
      .accept_valid (accept_valid),
      .accept_value (accept_value)
   );

   assign is_match = accept_valid && (accept_value == threshold);
   assign is_wrap  = accept_valid && (accept_value < count_stable_q);

   always_comb begin
      count_stable_d = count_stable_q;
      update_d       = accept_valid;
      match_d        = is_match;
      wrap_d         = is_wrap;
      if (accept_valid) begin
         count_stable_d = accept_value;
      end

      // A wrap in the clearing cycle is still counted.
      wrap_cnt_d = wrap_cnt_q;
      if (clr_event) begin
         wrap_cnt_d = WRAPW'(is_wrap);
      end else if (is_wrap && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + WRAPW'(1);
      end

      state_d = state_q;
      unique case (state_q)
         IDLE:  if (en_in) state_d = ARMED;
         ARMED: begin
            if (is_match)    state_d = HIT;
            else if (!en_in) state_d = IDLE;
         end
         HIT:   if (clr_event) state_d = en_in ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_stable_q <= '0;
         update_q       <= 1'b0;
         match_q        <= 1'b0;
         wrap_q         <= 1'b0;
         wrap_cnt_q     <= '0;
         state_q        <= IDLE;
      end else begin
         count_stable_q <= count_stable_d;
         update_q       <= update_d;
         match_q        <= match_d;
         wrap_q         <= wrap_d;
         wrap_cnt_q     <= wrap_cnt_d;
         state_q        <= state_d;
      end
   end

   assign count_stable = count_stable_q;
   assign update       = update_q;
   assign match        = match_q;
   assign wrap         = wrap_q;
   assign wrap_cnt     = wrap_cnt_q;
   assign hit          = (state_q == HIT);

`ifdef COUNT_MONITOR_IRQ_EN
   logic irq_q, irq_d;

   // Set wins over clear when a pulse and clr_event coincide.
   always_comb begin
      irq_d = irq_q;
      if (match_q || wrap_q) begin
         irq_d = 1'b1;
      end else if (clr_event) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor with default parameters.
module tb_count_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count_in;
   logic       en_in;
   logic [3:0] threshold;
   logic       clr_event;
   logic [3:0] count_stable;
   logic       update, match, wrap, hit, irq;
   logic [7:0] wrap_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   count_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .count_in     (count_in),
      .en_in        (en_in),
      .threshold    (threshold),
      .clr_event    (clr_event),
      .count_stable (count_stable),
      .update       (update),
      .match        (match),
      .wrap         (wrap),
      .wrap_cnt     (wrap_cnt),
      .hit          (hit),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cnt;
      logic       en;
      logic       clr;
      logic [3:0] cs;
      logic       upd;
      logic       mat;
      logic       wrp;
      logic       hit;
      logic [7:0] wcnt;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present v and wait the 4 edges needed for it to be accepted.
   task automatic settle(input logic [3:0] v);
      count_in = v;
      repeat (4) tick();
   endtask

   task automatic check_irq_zero(input string name);
`ifndef COUNT_MONITOR_IRQ_EN
      check(name, 32'(irq), 32'd0);
`endif
   endtask

   initial begin
      // cnt en clr | cs upd mat wrp hit wcnt
      vecs[0]  = '{4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{4'd7, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{4'd7, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{4'd7, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      // one-cycle glitch to 6, then 8
      vecs[9]  = '{4'd6, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{4'd8, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[11] = '{4'd8, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[12] = '{4'd8, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[13] = '{4'd8, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      // arm, then match on 9
      vecs[14] = '{4'd8, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[15] = '{4'd9, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[16] = '{4'd9, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[17] = '{4'd9, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[18] = '{4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
      // en drop keeps HIT; clr with en=0 returns to IDLE; en re-arms
      vecs[19] = '{4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[20] = '{4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[21] = '{4'd9, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[22] = '{4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[23] = '{4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

      rst       = 1'b1;
      count_in  = 4'd0;
      en_in     = 1'b0;
      threshold = 4'd9;
      clr_event = 1'b0;
      repeat (2) tick();
      check("reset count_stable", 32'(count_stable), 32'd0);
      check("reset update", 32'(update), 32'd0);
      check("reset match", 32'(match), 32'd0);
      check("reset wrap", 32'(wrap), 32'd0);
      check("reset wrap_cnt", 32'(wrap_cnt), 32'd0);
      check("reset hit", 32'(hit), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         count_in  = vecs[i].cnt;
         en_in     = vecs[i].en;
         clr_event = vecs[i].clr;
         tick();
         check($sformatf("vec%0d count_stable", i), 32'(count_stable), 32'(vecs[i].cs));
         check($sformatf("vec%0d update", i), 32'(update), 32'(vecs[i].upd));
         check($sformatf("vec%0d match", i), 32'(match), 32'(vecs[i].mat));
         check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].wrp));
         check($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].hit));
         check($sformatf("vec%0d wrap_cnt", i), 32'(wrap_cnt), 32'(vecs[i].wcnt));
      end
      clr_event = 1'b0;
      check_irq_zero("irq after table");

      // Multi-step jump 9->14 then 15, 0, 1: one wrap, on the 0 accept.
      settle(4'd14);
      check("jump 14 update", 32'(update), 32'd1);
      check("jump 14 wrap", 32'(wrap), 32'd0);
      settle(4'd15);
      check("step 15 wrap", 32'(wrap), 32'd0);
      settle(4'd0);
      check("step 0 count_stable", 32'(count_stable), 32'd0);
      check("step 0 wrap", 32'(wrap), 32'd1);
      check("step 0 wrap_cnt", 32'(wrap_cnt), 32'd1);
      tick();
      check("wrap pulse width", 32'(wrap), 32'd0);
      settle(4'd1);
      check("step 1 wrap", 32'(wrap), 32'd0);
      check("step 1 wrap_cnt", 32'(wrap_cnt), 32'd1);

      // Full 0..15 sweeps: one wrap per sweep, saturating at 255.
      for (int r = 0; r < 300; r++) begin
         for (int v = 0; v < 16; v++) settle(4'(v));
         if (r == 9) check("wrap_cnt after 10 sweeps", 32'(wrap_cnt), 32'd11);
      end
      check("wrap_cnt saturated", 32'(wrap_cnt), 32'd255);
      check("hit held through sweeps", 32'(hit), 32'd1);
      check_irq_zero("irq after sweeps");

      // clr_event coincides with the wrap accept 15->0.
      count_in = 4'd0;
      repeat (3) tick();
      clr_event = 1'b1;
      tick();
      clr_event = 1'b0;
      check("simul wrap", 32'(wrap), 32'd1);
      check("simul wrap_cnt", 32'(wrap_cnt), 32'd1);
      check("simul hit left", 32'(hit), 32'd0);
`ifdef COUNT_MONITOR_IRQ_EN
      check("simul irq cleared", 32'(irq), 32'd0);
`endif
      tick();
`ifdef COUNT_MONITOR_IRQ_EN
      check("simul irq set", 32'(irq), 32'd1);
`else
      check("simul irq", 32'(irq), 32'd0);
`endif

      // Plain clear.
      clr_event = 1'b1;
      tick();
      clr_event = 1'b0;
      check("clr wrap_cnt", 32'(wrap_cnt), 32'd0);
      check("clr keeps count_stable", 32'(count_stable), 32'd0);
      check("clr irq", 32'(irq), 32'd0);

      // Asynchronous reset between edges with count_stable = 12.
      settle(4'd12);
      check("pre-reset count_stable", 32'(count_stable), 32'd12);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("async rst count_stable", 32'(count_stable), 32'd0);
      check("async rst update", 32'(update), 32'd0);
      check("async rst wrap_cnt", 32'(wrap_cnt), 32'd0);
      check("async rst hit", 32'(hit), 32'd0);
      check("async rst irq", 32'(irq), 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("post-rst not yet", 32'(count_stable), 32'd0);
      tick();
      check("post-rst count_stable", 32'(count_stable), 32'd12);
      check("post-rst update", 32'(update), 32'd1);
      check("post-rst wrap", 32'(wrap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
